// File: rtl/tlp_rx_parser_pkg.sv
// tlp_rx_parser_pkg: TLP type codes, DW0 field offsets and parser states
// shared by the RX parser and its realign helper.
package tlp_rx_parser_pkg;

  localparam logic [6:0] FMT_TYPE_MWR32 = 7'h40;
  localparam logic [6:0] FMT_TYPE_MWR64 = 7'h60;

  localparam int FT_LSB  = 24;
  localparam int FT_MSB  = 30;
  localparam int EP_BIT  = 14;
  localparam int LEN_MSB = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_DATA,
    S_FLUSH,
    S_DROP
  } state_e;

  // A length field of zero encodes the maximum of 1024 dwords.
  function automatic logic [11:0] len_dw(input logic [LEN_MSB:0] len);
    return (len == '0) ? 12'd1024 : {2'b00, len};
  endfunction

endpackage

// File: rtl/tlp_rx_align.sv
// tlp_rx_align: one-dword hold register and lane mux that shifts
// 3DW-header payload down by one dword.
module tlp_rx_align (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] din_i,
  input  logic [31:0] lo_i,
  output logic [63:0] word_o
);

  logic [31:0] held_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      held_q <= '0;
    end else if (load_i) begin
      held_q <= din_i;
    end
  end

  assign word_o = flush_i ? {32'h0, held_q} : {lo_i, held_q};

endmodule

// File: rtl/tlp_rx_parser.sv
// tlp_rx_parser: splits posted MWr TLPs from the 64-bit RX stream into
// header records and a dword-realigned payload stream; drops the rest.
module tlp_rx_parser
  import tlp_rx_parser_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int C_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [C_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [7:0]              m_axis_rx_tkeep,
  input  logic                    m_axis_rx_tlast,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  input  logic                    rx_err_fwd,
  input  logic                    hdr_full,
  output logic                    hdr_wr_en,
  output logic [127:0]            hdr_wr_data,
  output logic                    hdr_wr_err,
  input  logic                    pd_full,
  output logic                    pd_wr_en,
  output logic [63:0]             pd_wr_data,
  output logic [1:0]              pd_wr_keep,
  output logic                    pd_wr_last,
  output logic [C_CNT_WIDTH-1:0]  drop_cnt,
  output logic [C_CNT_WIDTH-1:0]  len_err_cnt
);

  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE =
    {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic is4_q, is4_d;
  logic efw_q, efw_d;
  logic [31:0] dw0_q, dw0_d, dw1_q, dw1_d;
  logic [31:0] ahi_q, ahi_d, alo_q, alo_d;
  logic [9:0] len_q, len_d;
  logic [11:0] cnt_q, cnt_d;
  logic hwe_q, hwe_d, herr_q, herr_d;
  logic [127:0] hwd_q, hwd_d;
  logic pwe_q, pwe_d, pwl_q, pwl_d;
  logic [63:0] pwd_q, pwd_d;
  logic [1:0] pwk_q, pwk_d;
  logic [C_CNT_WIDTH-1:0] drop_q, drop_d, lerr_q, lerr_d;

  logic [63:0] td;
  logic [6:0] ft;
  logic acc, mwr, hi_v, fin, ld, flush, lenbad;
  logic [63:0] word;

  assign td = m_axis_rx_tdata;
  assign ft = td[FT_MSB:FT_LSB];
  assign hi_v = (m_axis_rx_tkeep == 8'hFF);
  assign mwr = ((ft == FMT_TYPE_MWR32) || (ft == FMT_TYPE_MWR64))
             && !td[EP_BIT];

  assign m_axis_rx_tready = !rst && !hdr_full && !pd_full
                          && (state_q != S_FLUSH);
  assign acc = m_axis_rx_tvalid && m_axis_rx_tready;

  tlp_rx_align u_align (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .flush_i (flush),
    .din_i   (td[63:32]),
    .lo_i    (td[31:0]),
    .word_o  (word)
  );

  always_comb begin
    state_d = state_q;
    is4_d = is4_q;
    efw_d = efw_q;
    dw0_d = dw0_q;
    dw1_d = dw1_q;
    ahi_d = ahi_q;
    alo_d = alo_q;
    len_d = len_q;
    cnt_d = cnt_q;
    hwe_d = 1'b0;
    hwd_d = hwd_q;
    herr_d = herr_q;
    pwe_d = 1'b0;
    pwd_d = pwd_q;
    pwk_d = pwk_q;
    pwl_d = pwl_q;
    drop_d = drop_q;
    lerr_d = lerr_q;
    fin = 1'b0;
    ld = 1'b0;
    flush = 1'b0;
    lenbad = 1'b0;
    unique case (state_q)
      S_IDLE: if (acc) begin
        dw0_d = td[31:0];
        dw1_d = td[63:32];
        is4_d = (ft == FMT_TYPE_MWR64);
        len_d = td[LEN_MSB:0];
        cnt_d = '0;
        efw_d = rx_err_fwd;
        ahi_d = '0;
        alo_d = '0;
        if (mwr && !m_axis_rx_tlast) begin
          state_d = S_HDR1;
        end else if (m_axis_rx_tlast) begin
          drop_d = drop_q + CNT_ONE;
        end else begin
          state_d = S_DROP;
        end
      end
      S_HDR1: if (acc) begin
        efw_d = efw_q | rx_err_fwd;
        if (is4_q) begin
          ahi_d = td[31:0];
          alo_d = td[63:32];
          if (m_axis_rx_tlast) fin = 1'b1;
          else state_d = S_DATA;
        end else begin
          alo_d = td[31:0];
          ld = hi_v;
          cnt_d = {11'b0, hi_v};
          if (!m_axis_rx_tlast) state_d = S_DATA;
          else if (hi_v) state_d = S_FLUSH;
          else fin = 1'b1;
        end
      end
      S_DATA: if (acc) begin
        efw_d = efw_q | rx_err_fwd;
        cnt_d = cnt_q + (hi_v ? 12'd2 : 12'd1);
        pwe_d = 1'b1;
        if (is4_q) begin
          pwd_d = td;
          pwk_d = hi_v ? 2'b11 : 2'b01;
          pwl_d = m_axis_rx_tlast;
          fin = m_axis_rx_tlast;
        end else begin
          pwd_d = word;
          pwk_d = 2'b11;
          ld = hi_v;
          pwl_d = m_axis_rx_tlast && !hi_v;
          if (m_axis_rx_tlast && hi_v) state_d = S_FLUSH;
          else fin = m_axis_rx_tlast;
        end
      end
      S_FLUSH: if (!pd_full && !hdr_full) begin
        flush = 1'b1;
        pwe_d = 1'b1;
        pwd_d = word;
        pwk_d = 2'b01;
        pwl_d = 1'b1;
        fin = 1'b1;
      end
      S_DROP: if (acc && m_axis_rx_tlast) begin
        drop_d = drop_q + CNT_ONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Header is emitted alongside the final payload word of the TLP.
    if (fin) begin
      state_d = S_IDLE;
      lenbad = (cnt_d != len_dw(len_q));
      hwe_d = 1'b1;
      hwd_d = {ahi_d, alo_d, dw1_q, dw0_q};
      herr_d = lenbad || efw_d;
      if (lenbad) lerr_d = lerr_q + CNT_ONE;
      if (efw_d) drop_d = drop_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      is4_q <= 1'b0;
      efw_q <= 1'b0;
      dw0_q <= '0;
      dw1_q <= '0;
      ahi_q <= '0;
      alo_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      hwe_q <= 1'b0;
      hwd_q <= '0;
      herr_q <= 1'b0;
      pwe_q <= 1'b0;
      pwd_q <= '0;
      pwk_q <= '0;
      pwl_q <= 1'b0;
      drop_q <= '0;
      lerr_q <= '0;
    end else begin
      state_q <= state_d;
      is4_q <= is4_d;
      efw_q <= efw_d;
      dw0_q <= dw0_d;
      dw1_q <= dw1_d;
      ahi_q <= ahi_d;
      alo_q <= alo_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      hwe_q <= hwe_d;
      hwd_q <= hwd_d;
      herr_q <= herr_d;
      pwe_q <= pwe_d;
      pwd_q <= pwd_d;
      pwk_q <= pwk_d;
      pwl_q <= pwl_d;
      drop_q <= drop_d;
      lerr_q <= lerr_d;
    end
  end

  assign hdr_wr_en = hwe_q;
  assign hdr_wr_data = hwd_q;
  assign hdr_wr_err = herr_q;
  assign pd_wr_en = pwe_q;
  assign pd_wr_data = pwd_q;
  assign pd_wr_keep = pwk_q;
  assign pd_wr_last = pwl_q;
  assign drop_cnt = drop_q;
  assign len_err_cnt = lerr_q;

endmodule

// File: tb/tb_tlp_rx_parser.sv
// tb_tlp_rx_parser: directed and randomized TLP streams checked against
// a dword-list reference model of MWr header/payload extraction.
module tb_tlp_rx_parser;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] tdata;
  logic [7:0] tkeep;
  logic tlast, tvalid, tready, err_fwd, hdr_full, pd_full;
  logic hwe, hwerr, pwe, pwl;
  logic [127:0] hwd;
  logic [63:0] pwd;
  logic [1:0] pwk;
  logic [15:0] dcnt, lcnt;

  always #5 clk = ~clk;

  tlp_rx_parser dut (
    .clk              (clk),
    .rst              (rst),
    .m_axis_rx_tdata  (tdata),
    .m_axis_rx_tkeep  (tkeep),
    .m_axis_rx_tlast  (tlast),
    .m_axis_rx_tvalid (tvalid),
    .m_axis_rx_tready (tready),
    .rx_err_fwd       (err_fwd),
    .hdr_full         (hdr_full),
    .hdr_wr_en        (hwe),
    .hdr_wr_data      (hwd),
    .hdr_wr_err       (hwerr),
    .pd_full          (pd_full),
    .pd_wr_en         (pwe),
    .pd_wr_data       (pwd),
    .pd_wr_keep       (pwk),
    .pd_wr_last       (pwl),
    .drop_cnt         (dcnt),
    .len_err_cnt      (lcnt)
  );

  typedef struct { logic [63:0] d; logic [1:0] k; logic l; } pd_t;
  typedef struct { logic [127:0] d; logic e; } hd_t;

  pd_t got_pd[$], exp_pd[$];
  hd_t got_hd[$], exp_hd[$];
  logic [31:0] txq[$];
  logic [31:0] pl[$];
  int exp_drop, exp_lerr;
  int n_chk, n_fail;
  bit rand_full, rand_gap;
  pd_t mp;
  hd_t mh;

  always @(negedge clk) begin
    if (!rst) begin
      if (pwe) begin
        mp.d = pwd; mp.k = pwk; mp.l = pwl;
        got_pd.push_back(mp);
      end
      if (hwe) begin
        mh.d = hwd; mh.e = hwerr;
        got_hd.push_back(mh);
      end
    end
  end

  task automatic fill_pl(input int n);
    pl = {};
    repeat (n) pl.push_back($urandom);
  endtask

  // Model: payload pairs into lanes in order; header mirrors the TLP.
  task automatic build_mwr(input bit is4, input logic [9:0] len,
                           input logic [63:0] addr, input bit errf);
    logic [31:0] dw0, dw1;
    int n, le;
    pd_t p;
    hd_t h;
    n = pl.size();
    le = (len == 0) ? 1024 : int'(len);
    dw0 = {1'b0, is4 ? 7'h60 : 7'h40, 8'($urandom), 1'b0, 1'b0,
           4'($urandom), len};
    dw1 = $urandom;
    txq = {};
    txq.push_back(dw0);
    txq.push_back(dw1);
    if (is4) begin
      txq.push_back(addr[63:32]);
      txq.push_back(addr[31:0]);
    end else begin
      txq.push_back(addr[31:0]);
    end
    foreach (pl[i]) txq.push_back(pl[i]);
    for (int k = 0; 2 * k < n; k++) begin
      p.d = {(2 * k + 1 < n) ? pl[2 * k + 1] : 32'h0, pl[2 * k]};
      p.k = (2 * k + 1 < n) ? 2'b11 : 2'b01;
      p.l = (2 * k + 2 >= n);
      exp_pd.push_back(p);
    end
    h.d = {is4 ? addr[63:32] : 32'h0, addr[31:0], dw1, dw0};
    h.e = (n != le) || errf;
    exp_hd.push_back(h);
    if (n != le) exp_lerr++;
    if (errf) exp_drop++;
  endtask

  task automatic build_drop(input logic [6:0] ft, input bit ep,
                            input int npl);
    int hdw;
    hdw = ft[5] ? 4 : 3;
    txq = {};
    txq.push_back({1'b0, ft, 8'($urandom), 1'b0, ep, 4'($urandom),
                   10'(npl)});
    repeat (hdw - 1 + npl) txq.push_back($urandom);
    exp_drop++;
  endtask

  task automatic send(input int errbeat, input int maxb);
    int sz, nb, waited;
    bit ok;
    sz = txq.size();
    nb = (sz + 1) / 2;
    for (int b = 0; b < nb && b < maxb; b++) begin
      if (rand_gap) begin
        tvalid = 1'b0;
        while ($urandom % 4 == 0) @(negedge clk);
      end
      tdata = {(2 * b + 1 < sz) ? txq[2 * b + 1] : 32'h0, txq[2 * b]};
      tkeep = (2 * b + 1 < sz) ? 8'hFF : 8'h0F;
      tlast = (b == nb - 1);
      err_fwd = (b == errbeat);
      tvalid = 1'b1;
      waited = 0;
      forever begin
        if (rand_full) begin
          pd_full = ($urandom % 5 == 0);
          hdr_full = ($urandom % 7 == 0);
        end
        #1;
        ok = tready;
        @(negedge clk);
        if (ok) break;
        waited++;
        if (waited > 200) break;
      end
      if (waited > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL handshake_timeout beat %0d tready %b want 1", b,
                 tready);
        break;
      end
    end
    tvalid = 1'b0;
    tlast = 1'b0;
    err_fwd = 1'b0;
    if (rand_full) begin
      pd_full = 1'b0;
      hdr_full = 1'b0;
    end
  endtask

  task automatic drain();
    tvalid = 1'b0;
    pd_full = 1'b0;
    hdr_full = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic clear_q();
    got_pd = {}; exp_pd = {}; got_hd = {}; exp_hd = {};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (tready !== 1'b0 || hwe !== 1'b0 || pwe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes tready/hwe/pwe %b%b%b want 000",
               tready, hwe, pwe);
    end
    n_chk++;
    if (dcnt !== 16'd0 || lcnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_counters drop %0d lenerr %0d want 0 0",
               dcnt, lcnt);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_mwr();
    clear_q();
    pl = {32'hAABBCCDD};
    build_mwr(1'b0, 10'd1, 64'h1000, 1'b0);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_pd.size() !== 1 || got_hd.size() !== 1) begin
      n_fail++;
      $display("FAIL len1_counts pd %0d hdr %0d want 1 1",
               got_pd.size(), got_hd.size());
    end else begin
      n_chk++;
      if (got_pd[0].d[31:0] !== 32'hAABBCCDD || got_pd[0].k !== 2'b01
          || got_pd[0].l !== 1'b1) begin
        n_fail++;
        $display("FAIL len1_pd got %h/%b/%b want aabbccdd/01/1",
                 got_pd[0].d[31:0], got_pd[0].k, got_pd[0].l);
      end
      n_chk++;
      if (got_hd[0].d[127:64] !== 64'h1000 || got_hd[0].e !== 1'b0) begin
        n_fail++;
        $display("FAIL len1_hdr addr %h err %b want 1000 0",
                 got_hd[0].d[127:64], got_hd[0].e);
      end
    end
    clear_q();
    fill_pl(4);
    build_mwr(1'b0, 10'd4, 64'h2000, 1'b0);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_pd.size() !== 2 || got_hd.size() !== 1) begin
      n_fail++;
      $display("FAIL len4_counts pd %0d hdr %0d want 2 1",
               got_pd.size(), got_hd.size());
    end else begin
      n_chk++;
      if (got_pd[0].d !== {pl[1], pl[0]} || got_pd[0].k !== 2'b11
          || got_pd[0].l !== 1'b0 || got_pd[1].d !== {pl[3], pl[2]}
          || got_pd[1].k !== 2'b11 || got_pd[1].l !== 1'b1
          || got_hd[0].e !== 1'b0) begin
        n_fail++;
        $display("FAIL len4_words got %h/%b/%b %h/%b/%b err %b want %h/11/0 %h/11/1 err 0",
                 got_pd[0].d, got_pd[0].k, got_pd[0].l, got_pd[1].d,
                 got_pd[1].k, got_pd[1].l, got_hd[0].e,
                 {pl[1], pl[0]}, {pl[3], pl[2]});
      end
    end
    clear_q();
    fill_pl(3);
    build_mwr(1'b1, 10'd3, 64'h1_0000_2000, 1'b0);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_pd.size() !== 2 || got_hd.size() !== 1) begin
      n_fail++;
      $display("FAIL mwr64_counts pd %0d hdr %0d want 2 1",
               got_pd.size(), got_hd.size());
    end else begin
      n_chk++;
      if (got_pd[0].k !== 2'b11 || got_pd[1].k !== 2'b01
          || got_pd[1].l !== 1'b1 || got_pd[1].d[31:0] !== pl[2]
          || got_hd[0].d[127:96] !== 32'h1
          || got_hd[0].d[95:64] !== 32'h2000) begin
        n_fail++;
        $display("FAIL mwr64 keep %b %b last %b hi %h lo %h want 11 01 1 1 2000",
                 got_pd[0].k, got_pd[1].k, got_pd[1].l,
                 got_hd[0].d[127:96], got_hd[0].d[95:64]);
      end
    end
  endtask

  task automatic test_drops();
    clear_q();
    build_drop(7'h00, 1'b0, 0);
    send(-1, 1000);
    build_drop(7'h4A, 1'b0, 2);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_pd.size() !== 0 || got_hd.size() !== 0 || dcnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL drop_b2b pd %0d hdr %0d drop %0d want 0 0 %0d",
               got_pd.size(), got_hd.size(), dcnt, exp_drop);
    end
    build_drop(7'h40, 1'b1, 3);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_hd.size() !== 0 || dcnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL drop_poisoned hdr %0d drop %0d want 0 %0d",
               got_hd.size(), dcnt, exp_drop);
    end
  endtask

  task automatic test_len_err();
    clear_q();
    fill_pl(1);
    build_mwr(1'b0, 10'd2, 64'h3000, 1'b0);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_hd.size() !== 1 || got_pd.size() !== 1) begin
      n_fail++;
      $display("FAIL lenerr_counts hdr %0d pd %0d want 1 1",
               got_hd.size(), got_pd.size());
    end else if (got_hd[0].e !== 1'b1 || got_pd[0].l !== 1'b1
                 || lcnt !== 16'(exp_lerr)) begin
      n_fail++;
      $display("FAIL lenerr err %b last %b cnt %0d want 1 1 %0d",
               got_hd[0].e, got_pd[0].l, lcnt, exp_lerr);
    end
    clear_q();
    fill_pl(1024);
    build_mwr(1'b0, 10'd0, 64'h4000, 1'b0);
    send(-1, 1000);
    drain();
    n_chk++;
    if (got_hd.size() !== 1 || got_pd.size() !== 512) begin
      n_fail++;
      $display("FAIL len1024_counts hdr %0d pd %0d want 1 512",
               got_hd.size(), got_pd.size());
    end else if (got_hd[0].e !== 1'b0 || got_pd[511].l !== 1'b1
                 || got_pd[511].d !== exp_pd[511].d
                 || lcnt !== 16'(exp_lerr)) begin
      n_fail++;
      $display("FAIL len1024 err %b last %b cnt %0d want 0 1 %0d",
               got_hd[0].e, got_pd[511].l, lcnt, exp_lerr);
    end
  endtask

  task automatic test_err_fwd();
    clear_q();
    fill_pl(6);
    build_mwr(1'b1, 10'd6, 64'h5_0000_0040, 1'b1);
    send(3, 1000);
    drain();
    n_chk++;
    if (got_pd.size() !== 3 || got_hd.size() !== 1) begin
      n_fail++;
      $display("FAIL errfwd_counts pd %0d hdr %0d want 3 1",
               got_pd.size(), got_hd.size());
    end else if (got_hd[0].e !== 1'b1 || got_pd[2].d !== exp_pd[2].d
                 || dcnt !== 16'(exp_drop)) begin
      n_fail++;
      $display("FAIL errfwd err %b pd2 %h drop %0d want 1 %h %0d",
               got_hd[0].e, got_pd[2].d, dcnt, exp_pd[2].d, exp_drop);
    end
  endtask

  task automatic test_stall_reset();
    int base_hd, base_pd;
    clear_q();
    fill_pl(8);
    build_mwr(1'b1, 10'd8, 64'h0_0000_8000, 1'b0);
    fork
      send(-1, 1000);
      begin
        repeat (3) @(negedge clk);
        pd_full = 1'b1;
        repeat (5) @(negedge clk);
        pd_full = 1'b0;
      end
    join
    drain();
    n_chk++;
    if (got_pd.size() !== 4 || got_hd.size() !== 1) begin
      n_fail++;
      $display("FAIL stall_counts pd %0d hdr %0d want 4 1",
               got_pd.size(), got_hd.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_chk++;
        if (got_pd[i].d !== exp_pd[i].d || got_pd[i].k !== 2'b11
            || got_pd[i].l !== (i == 3)) begin
          n_fail++;
          $display("FAIL stall_pd[%0d] got %h/%b/%b want %h/11/%b", i,
                   got_pd[i].d, got_pd[i].k, got_pd[i].l, exp_pd[i].d,
                   i == 3);
        end
      end
      n_chk++;
      if (got_hd[0].d !== exp_hd[0].d || got_hd[0].e !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hdr got %h/%b want %h/0", got_hd[0].d,
                 got_hd[0].e, exp_hd[0].d);
      end
    end
    base_hd = got_hd.size();
    base_pd = got_pd.size();
    fill_pl(8);
    build_mwr(1'b1, 10'd8, 64'h0_0000_9000, 1'b0);
    send(-1, 2);
    tdata = {txq[5], txq[4]};
    tkeep = 8'hFF;
    tvalid = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (tready !== 1'b0 || hwe !== 1'b0 || pwe !== 1'b0) begin
      n_fail++;
      $display("FAIL midtlp_reset tready/hwe/pwe %b%b%b want 000",
               tready, hwe, pwe);
    end
    rst = 1'b0;
    tvalid = 1'b0;
    drain();
    n_chk++;
    if (got_hd.size() !== base_hd || got_pd.size() !== base_pd
        || dcnt !== 16'd0 || lcnt !== 16'd0) begin
      n_fail++;
      $display("FAIL after_reset hdr %0d pd %0d drop %0d lenerr %0d want %0d %0d 0 0",
               got_hd.size(), got_pd.size(), dcnt, lcnt, base_hd, base_pd);
    end
    exp_drop = 0;
    exp_lerr = 0;
  endtask

  task automatic test_random_back_to_back();
    int n, hdw, nb, eb;
    bit is4;
    logic [9:0] len;
    logic [6:0] ft;
    clear_q();
    rand_full = 1'b1;
    rand_gap = 1'b1;
    for (int t = 0; t < 80; t++) begin
      if ($urandom % 6 == 0) begin
        case ($urandom % 5)
          0: ft = 7'h00;
          1: ft = 7'h20;
          2: ft = 7'h4A;
          3: ft = 7'h0A;
          default: ft = 7'h60;
        endcase
        build_drop(ft, ft == 7'h60, int'($urandom_range(0, 5)));
        eb = ($urandom % 3 == 0) ? 1 : -1;
      end else begin
        is4 = $urandom % 2;
        n = $urandom_range(1, 12);
        len = ($urandom % 4 == 0) ? 10'($urandom_range(0, 12)) : 10'(n);
        hdw = is4 ? 4 : 3;
        nb = (hdw + n + 1) / 2;
        eb = ($urandom % 6 == 0) ? int'($urandom_range(0, nb - 1)) : -1;
        fill_pl(n);
        build_mwr(is4, len, {$urandom, $urandom}, eb >= 0);
      end
      send(eb, 1000);
    end
    rand_full = 1'b0;
    rand_gap = 1'b0;
    drain();
    n_chk++;
    if (got_pd.size() !== exp_pd.size() || got_hd.size() !== exp_hd.size()) begin
      n_fail++;
      $display("FAIL rand_counts pd %0d hdr %0d want %0d %0d",
               got_pd.size(), got_hd.size(), exp_pd.size(), exp_hd.size());
    end
    for (int i = 0; i < exp_pd.size() && i < got_pd.size(); i++) begin
      n_chk++;
      if (got_pd[i].d[31:0] !== exp_pd[i].d[31:0]
          || got_pd[i].k !== exp_pd[i].k || got_pd[i].l !== exp_pd[i].l
          || (exp_pd[i].k == 2'b11
              && got_pd[i].d[63:32] !== exp_pd[i].d[63:32])) begin
        n_fail++;
        $display("FAIL rand_pd[%0d] got %h/%b/%b want %h/%b/%b", i,
                 got_pd[i].d, got_pd[i].k, got_pd[i].l, exp_pd[i].d,
                 exp_pd[i].k, exp_pd[i].l);
      end
    end
    for (int i = 0; i < exp_hd.size() && i < got_hd.size(); i++) begin
      n_chk++;
      if (got_hd[i].d !== exp_hd[i].d || got_hd[i].e !== exp_hd[i].e) begin
        n_fail++;
        $display("FAIL rand_hdr[%0d] got %h/%b want %h/%b", i,
                 got_hd[i].d, got_hd[i].e, exp_hd[i].d, exp_hd[i].e);
      end
    end
    n_chk++;
    if (dcnt !== 16'(exp_drop) || lcnt !== 16'(exp_lerr)) begin
      n_fail++;
      $display("FAIL rand_counters drop %0d lenerr %0d want %0d %0d",
               dcnt, lcnt, exp_drop, exp_lerr);
    end
  endtask

  initial begin
    rst = 1'b1;
    tdata = '0;
    tkeep = '0;
    tlast = 1'b0;
    tvalid = 1'b0;
    err_fwd = 1'b0;
    hdr_full = 1'b0;
    pd_full = 1'b0;
    n_chk = 0;
    n_fail = 0;
    exp_drop = 0;
    exp_lerr = 0;
    rand_full = 1'b0;
    rand_gap = 1'b0;
    test_reset();
    test_basic_mwr();
    test_drops();
    test_len_err();
    test_err_fwd();
    test_stall_reset();
    test_random_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
